data_memory_controller: RTL
===========================

// Module: data_memory_controller
// PURPOSE
//  Responder side of the memory-stage data bus: accepts read/write requests (read, write,
//  memory_addr, data_to_write), performs them on an internal word-addressed RAM after a
//  programmable wait latency and returns read data with a one-cycle ready pulse. Sits between
//  the memory pipeline stage and the data RAM; the memory stage stalls until ready.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words in the data RAM (power of 2)
//  LATENCY  2     wait cycles inserted before the access completes (0..15)
// PORTS
//  clk                      in   1   clock, all logic on rising edge
//  rst                      in   1   reset, synchronous, active-high
//  read                     in   1   read request, held by requester until ready
//  write                    in   1   write request, held by requester until ready
//  memory_addr              in   32  byte address; word index = memory_addr[$clog2(DEPTH)+1:2]
//  data_to_write            in   32  store data
//  read_data_to_memory      out  32  load data, valid while ready=1 for a read
//  ready                    out  1   one-cycle completion pulse
//  busy                     out  1   request accepted and not yet completed
//  access_error             out  1   completion carried an error (valid with ready)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, ready=0, busy=0, access_error=0,
//    read_data_to_memory=0, counter=0. RAM contents not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: if (read|write) in cycle c: latch addr/data/op, busy<=1; go WAIT with cnt=LATENCY-1,
//      or straight to RESP if LATENCY==0.
//    WAIT: cnt decrements each cycle; at cnt==0 go RESP.
//    Entry into RESP (same edge): write commits to RAM / read word registered into
//      read_data_to_memory; ready<=1, busy<=0.
//    RESP: lasts exactly one cycle; requests ignored; then IDLE, ready<=0.
//  - Latency: request first present in IDLE cycle c -> ready=1 in cycle c+1+LATENCY.
//    Next request accepted earliest in cycle c+2+LATENCY.
//  - Inputs latched at accept; changes to inputs during WAIT/RESP have no effect.
//  - read & write both high at accept: treated as write, access_error=1 on completion.
//  - Addresses beyond DEPTH words wrap (upper bits ignored).
//  - read_data_to_memory holds its last value after a write or after ready drops.
//  - rst mid-operation: transaction aborted, no RAM write, no ready pulse; IDLE next cycle.
// CONFIGURATION
//  MEM_CTRL_ALIGN_CHECK_EN defined: memory_addr[1:0]!=0 at accept -> normal latency, ready pulse
//    with access_error=1, no RAM write, read_data_to_memory=0.
//  Not defined: memory_addr[1:0] ignored; misalignment never flags an error.
// STRUCTURE
//  - Package riscv_mem_pkg: DATA_W=32, ADDR_W=32, typedef enum logic[1:0] {IDLE,WAIT,RESP}
//    mem_ctrl_state_t, typedef enum logic {OP_READ,OP_WRITE} mem_op_t.
//  - Sub-module dmem_array: single-port sync RAM (we, addr, wdata, rdata, 1-cycle read);
//    controller issues RAM read one cycle early (last WAIT, or accept edge if LATENCY==0).
// TESTING
//  1 Reset: rst=1 two cycles with read=1 -> ready=0, busy=0, read_data_to_memory=0.
//  2 Write 0x3FFFFFFF @0xFFFFFFFC then read @0xFFFFFFFC, LATENCY=2 -> each ready 3 cycles
//    after request; read returns 0x3FFFFFFF; word index DEPTH-1.
//  3 Wrap: write 0xDEADBEEF @0x00001000 (DEPTH=1024) -> read @0x0 returns 0xDEADBEEF.
//  4 read=1,write=1 @0x10 data 0x12345678 -> ready with access_error=1; later read @0x10
//    returns 0x12345678.
//  5 rst asserted in WAIT of write 0xAAAA5555 @0x20 -> no ready; read @0x20 returns prior value.
//  6 MEM_CTRL_ALIGN_CHECK_EN: write @0x22 -> access_error=1, RAM unchanged; without macro
//    write lands at word 8.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory controller: bus widths, FSM state and request record.
// Latency/backpressure: n/a (types only).
package riscv_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_ctrl_state_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

  // Request as captured at accept; err marks a read+write collision.
  typedef struct packed {
    mem_op_t             op;
    logic                err;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } mem_req_t;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Memory-stage data bus: requester (master) holds read/write until a one-cycle ready pulse.
// Latency/backpressure: set by the responder; busy flags an accepted, uncompleted request.
interface data_memory_controller_if;
  import riscv_mem_pkg::*;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] memory_addr;
  logic [DATA_W-1:0] data_to_write;
  logic [DATA_W-1:0] read_data_to_memory;
  logic              ready;
  logic              busy;
  logic              access_error;

  modport master (
    output read, write, memory_addr, data_to_write,
    input  read_data_to_memory, ready, busy, access_error
  );

  modport slave (
    input  read, write, memory_addr, data_to_write,
    output read_data_to_memory, ready, busy, access_error
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with a registered read port that doubles as the load-data output.
// Latency: 1 cycle read; backpressure: none, the controller sequences every access.
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register holds between reads; clr forces zero for a rejected access.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_controller.sv
// Data-memory responder: IDLE->WAIT->RESP, ready pulses LATENCY+1 cycles after a request appears.
// Backpressure: requester holds read/write until ready; MEM_CTRL_ALIGN_CHECK_EN rejects misaligned.
module data_memory_controller
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  data_memory_controller_if.slave  bus
);

  localparam int               AW       = $clog2(DEPTH);
  localparam bit               ZERO_LAT = (LATENCY == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = ZERO_LAT ? '0 : CNT_W'(LATENCY - 1);

  mem_ctrl_state_t   state;
  logic [CNT_W-1:0]  cnt;
  mem_req_t          req_q;
  mem_req_t          new_req;
  mem_req_t          cur_req;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic              accept;
  logic              commit;
  logic              cur_mis;
  logic              commit_err;
  logic              ram_we;
  logic              ram_re;
  logic              ram_clr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  always_comb begin
    new_req      = '0;
    new_req.op   = bus.write ? OP_WRITE : OP_READ;
    new_req.err  = bus.read & bus.write;
    new_req.addr = bus.memory_addr;
    new_req.data = bus.data_to_write;
  end

  // In IDLE the live bus is the request (zero-latency commit); afterwards only the latched copy counts.
  assign cur_req = (state == IDLE) ? new_req : req_q;
  assign accept  = (state == IDLE) && (bus.read || bus.write);
  assign commit  = !rst && ((ZERO_LAT && accept) || ((state == WAIT) && (cnt == '0)));

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign cur_mis = is_misaligned(cur_req.addr);
`else
  assign cur_mis = 1'b0;
`endif

  assign commit_err = cur_req.err | cur_mis;
  assign ram_we     = commit && (cur_req.op == OP_WRITE) && !cur_mis;
  assign ram_re     = commit && (cur_req.op == OP_READ) && !cur_mis;
  assign ram_clr    = commit && cur_mis;

  assign unused_addr_bits = ^{cur_req.addr[ADDR_W-1:AW+2], cur_req.addr[1:0]};

  // RAM is addressed during the last WAIT cycle so its read register lands on the RESP edge.
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .clr   (ram_clr),
    .addr  (cur_req.addr[AW+1:2]),
    .wdata (cur_req.data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (accept) begin
            req_q <= new_req;
            if (ZERO_LAT) begin
              state   <= RESP;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              err_q   <= commit_err;
            end else begin
              state  <= WAIT;
              cnt    <= CNT_INIT;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= commit_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready               = ready_q;
  assign bus.busy                = busy_q;
  assign bus.access_error        = err_q;
  assign bus.read_data_to_memory = ram_rdata;

endmodule
